flash_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the Gigatron CPU clock generator and the 8-bit parallel flash. It takes a 16-bit ROM word address from the CPU side. It runs two timed byte reads on the flash bus, assembles the 16-bit instruction, and reports completion with a level handshake that the clock generator uses to stretch the cycle. A one-entry last-address buffer skips the flash access when the same word is requested again. An optional sequential prefetch slot can be compiled in.

---
 rtl/flash_fetch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_flash_fetch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flash_fetch_ctrl.sv
// rtl/flash_fetch_ctrl.sv - Gigatron instruction fetch sequencer for an 8-bit parallel flash
// Optional sequential prefetch slot is compiled in with `define FETCH_PREFETCH_EN.
module flash_fetch_ctrl #(
   parameter int WAIT_CYCLES = 4,
   parameter int FL_ADDR_W   = 22
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   input  logic                 req,
   input  logic [15:0]          req_addr,
   output logic [15:0]          insn,
   output logic                 insn_rdy,
   output logic                 busy,
   output logic [FL_ADDR_W-1:0] FL_ADDR,
   output logic                 FL_OE_N,
   input  logic [7:0]           FL_DQ
);

   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, DONE
`ifdef FETCH_PREFETCH_EN
      , PF_LO, PF_HI
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt;
   logic [15:0] cur_addr;
   logic [7:0]  lo_byte;
   logic [15:0] hold_addr, hold_data;
   logic        hold_vld;
   logic        abandon;
   logic        wait_done, hold_hit, pf_hit;
   logic [15:0] rd_addr;
   logic        rd_byte;
`ifdef FETCH_PREFETCH_EN
   logic [15:0] pf_addr, pf_data;
   logic        pf_vld, pf_claim;
   logic        pf_abort, pf_take;
`endif

   always_comb begin
      wait_done = (wait_cnt == 4'(WAIT_CYCLES - 1));
      hold_hit  = hold_vld && (req_addr == hold_addr);
`ifdef FETCH_PREFETCH_EN
      pf_hit   = pf_vld && (req_addr == pf_addr);
      // once a matching request has been seen, later address changes are ignored
      pf_abort = req && !pf_claim && (req_addr != pf_addr);
      pf_take  = req && (pf_claim || (req_addr == pf_addr));
`else
      pf_hit   = 1'b0;
`endif
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_addr   = 16'h0000;
      rd_byte   = 1'b0;
      FL_OE_N   = 1'b1;
      busy      = 1'b0;
      insn_rdy  = 1'b0;
      case (state)
         IDLE: begin
            if (req) state_nxt = (hold_hit || pf_hit) ? DONE : RD_LO;
         end
         RD_LO: begin
            rd_addr = cur_addr;
            FL_OE_N = 1'b0;
            busy    = 1'b1;
            if (wait_done) state_nxt = RD_HI;
         end
         RD_HI: begin
            rd_addr = cur_addr;
            rd_byte = 1'b1;
            FL_OE_N = 1'b0;
            busy    = 1'b1;
            if (wait_done) state_nxt = (req && !abandon) ? DONE : IDLE;
         end
         DONE: begin
            insn_rdy = 1'b1;
`ifdef FETCH_PREFETCH_EN
            if (!req) state_nxt = PF_LO;
`else
            if (!req) state_nxt = IDLE;
`endif
         end
`ifdef FETCH_PREFETCH_EN
         PF_LO: begin
            rd_addr = pf_addr;
            FL_OE_N = 1'b0;
            busy    = 1'b1;
            if (pf_abort)       state_nxt = RD_LO;
            else if (wait_done) state_nxt = PF_HI;
         end
         PF_HI: begin
            rd_addr = pf_addr;
            rd_byte = 1'b1;
            FL_OE_N = 1'b0;
            busy    = 1'b1;
            if (pf_abort)       state_nxt = RD_LO;
            else if (wait_done) state_nxt = pf_take ? DONE : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      FL_ADDR = {{(FL_ADDR_W-17){1'b0}}, rd_addr, rd_byte};
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt  <= 4'd0;
         cur_addr  <= 16'h0000;
         lo_byte   <= 8'h00;
         hold_addr <= 16'h0000;
         hold_data <= 16'h0000;
         hold_vld  <= 1'b0;
         abandon   <= 1'b0;
         insn      <= 16'h0000;
`ifdef FETCH_PREFETCH_EN
         pf_addr   <= 16'h0000;
         pf_data   <= 16'h0000;
         pf_vld    <= 1'b0;
         pf_claim  <= 1'b0;
`endif
      end else begin
         // restart the byte timer on every state change
         wait_cnt <= (busy && state_nxt == state) ? wait_cnt + 4'd1 : 4'd0;
         case (state)
            IDLE: begin
               if (req) begin
                  cur_addr <= req_addr;
                  abandon  <= 1'b0;
                  if (hold_hit) begin
                     insn <= hold_data;
                  end
`ifdef FETCH_PREFETCH_EN
                  else if (pf_hit) begin
                     insn      <= pf_data;
                     hold_addr <= pf_addr;
                     hold_data <= pf_data;
                     hold_vld  <= 1'b1;
                  end
`endif
               end
            end
            RD_LO: begin
               if (!req) abandon <= 1'b1;
               if (wait_done) lo_byte <= FL_DQ;
            end
            RD_HI: begin
               if (!req) abandon <= 1'b1;
               if (wait_done) begin
                  hold_addr <= cur_addr;
                  hold_data <= {FL_DQ, lo_byte};
                  hold_vld  <= 1'b1;
                  if (req && !abandon) insn <= {FL_DQ, lo_byte};
               end
            end
            DONE: begin
`ifdef FETCH_PREFETCH_EN
               if (!req) begin
                  pf_addr  <= cur_addr + 16'd1;
                  pf_vld   <= 1'b0;
                  pf_claim <= 1'b0;
               end
`endif
            end
`ifdef FETCH_PREFETCH_EN
            PF_LO: begin
               if (pf_abort) begin
                  cur_addr <= req_addr;
                  abandon  <= 1'b0;
               end else begin
                  if (req) pf_claim <= 1'b1;
                  if (wait_done) lo_byte <= FL_DQ;
               end
            end
            PF_HI: begin
               if (pf_abort) begin
                  cur_addr <= req_addr;
                  abandon  <= 1'b0;
               end else begin
                  if (req) pf_claim <= 1'b1;
                  if (wait_done) begin
                     pf_data <= {FL_DQ, lo_byte};
                     pf_vld  <= 1'b1;
                     if (pf_take) begin
                        cur_addr  <= pf_addr;
                        hold_addr <= pf_addr;
                        hold_data <= {FL_DQ, lo_byte};
                        hold_vld  <= 1'b1;
                        insn      <= {FL_DQ, lo_byte};
                     end
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// tb/tb_flash_fetch_ctrl.sv - directed and randomized checks of flash_fetch_ctrl against a word-level model
module tb_flash_fetch_ctrl;
   localparam int W = 4;

   logic        CLOCK_50;
   logic        reset_n;
   logic        req;
   logic [15:0] req_addr;
   logic [15:0] insn;
   logic        insn_rdy;
   logic        busy;
   logic [21:0] FL_ADDR;
   logic        FL_OE_N;
   logic [7:0]  FL_DQ;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // model: one held word, one prefetched word, last delivered instruction
   logic [15:0] h_addr, p_addr, last_insn;
   logic        h_vld, p_vld;
   int          first;
   logic [15:0] ra;
   int          rd;

   flash_fetch_ctrl #(.WAIT_CYCLES(W), .FL_ADDR_W(22)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .insn(insn), .insn_rdy(insn_rdy), .busy(busy),
      .FL_ADDR(FL_ADDR), .FL_OE_N(FL_OE_N), .FL_DQ(FL_DQ)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] fb(input logic [16:0] ba);
      if (ba == 17'h0000A) return 8'h34;
      if (ba == 17'h0000B) return 8'h12;
      return ba[7:0] ^ ba[15:8] ^ {ba[16], 7'h25};
   endfunction

   function automatic logic [15:0] word(input logic [15:0] a);
      return {fb({a, 1'b1}), fb({a, 1'b0})};
   endfunction

   function automatic logic [31:0] bus_exp(input logic oe_n, input logic [15:0] a, input logic b);
      return 32'({oe_n, 5'b00000, a, b});
   endfunction

   assign FL_DQ = FL_OE_N ? 8'hFF : fb(FL_ADDR[16:0]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 60 && busy; n++) @(negedge CLOCK_50);
      check("idle", 32'(busy), 32'd0);
   endtask

   // Request a for d cycles (req high in cycles N..N+d-1); chg moves req_addr mid-fetch.
   task automatic run_req(input logic [15:0] a, input int d, input bit chg);
      bit          hit;
      int          lat;
      int          fst;
      logic [15:0] nxt;
      hit = (h_vld && a == h_addr) || (p_vld && a == p_addr);
      lat = hit ? 1 : 2*W + 1;
      nxt = a + 16'd1;
      fst = 0;
      req_addr = a;
      req      = 1'b1;
      for (int k = 1; k <= 2*W + 6; k++) begin
         @(negedge CLOCK_50);
         if (insn_rdy && fst == 0) begin
            fst = k;
            check("insn", 32'(insn), 32'(word(a)));
         end
         if (!hit && k <= 2*W)
            check("fl_bus", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b0, a, k > W));
         if (hit && k == 1)
            check("hit_no_oe", 32'(FL_OE_N), 32'd1);
         if (d >= lat && k == d + 1) begin
            check("rdy_fall", 32'(insn_rdy), 32'd0);
`ifdef FETCH_PREFETCH_EN
            check("pf_bus", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b0, nxt, 1'b0));
`endif
         end
         if (chg && k == 2) req_addr = a + 16'd1;
         req = (k < d);
      end
      check("rdy_cycle", 32'(fst), (d >= lat) ? 32'(lat) : 32'd0);
      wait_idle();
      h_addr = a;
      h_vld  = 1'b1;
      if (d >= lat) begin
         last_insn = word(a);
`ifdef FETCH_PREFETCH_EN
         p_addr = nxt;
         p_vld  = 1'b1;
`endif
      end
      check("insn_keep", 32'(insn), 32'(last_insn));
   endtask

   initial begin
      reset_n = 1'b0; req = 1'b0; req_addr = 16'h0000;
      h_vld = 1'b0; p_vld = 1'b0; h_addr = 16'h0; p_addr = 16'h0; last_insn = 16'h0;
      repeat (3) @(negedge CLOCK_50);
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      check("rst_insn", 32'(insn), 32'd0);
      check("rst_rdy", 32'(insn_rdy), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b1, 16'h0, 1'b0));

      run_req(16'h0005, 12, 1'b0);
      check("word5", 32'(insn), 32'h1234);
      run_req(16'h0005, 3, 1'b0);
      run_req(16'h0007, 2, 1'b0);
      run_req(16'h0007, 2, 1'b0);
      run_req(16'h0005, 12, 1'b1);
      check("addr_ignored", 32'(insn), 32'h1234);

      // reset during the high-byte read
      req_addr = 16'h0009; req = 1'b1;
      repeat (W + 2) @(negedge CLOCK_50);
      check("mid_rd_hi_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_insn", 32'(insn), 32'd0);
      check("async_rdy", 32'(insn_rdy), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_bus", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b1, 16'h0, 1'b0));
      req = 1'b0;
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      h_vld = 1'b0; p_vld = 1'b0; last_insn = 16'h0000;
      @(negedge CLOCK_50);
      run_req(16'h0000, 12, 1'b0);

      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 4))
            0: ra = 16'h0005;
            1: ra = 16'h0006;
            2: ra = 16'h1234;
            3: ra = 16'h1235;
            default: ra = 16'($urandom);
         endcase
         rd = int'($urandom_range(1, 2*W + 4));
         run_req(ra, rd, 1'b0);
      end

`ifdef FETCH_PREFETCH_EN
      run_req(16'hFFFF, 12, 1'b0);
      run_req(16'h0000, 3, 1'b0);
      check("wrap_hit_insn", 32'(insn), 32'(word(16'h0000)));

      // abort a prefetch with a non-matching request
      req_addr = 16'h00FE; req = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLOCK_50);
         if (insn_rdy) break;
      end
      check("pf_src_rdy", 32'(insn_rdy), 32'd1);
      req = 1'b0;
      @(negedge CLOCK_50);
      check("pf_lo_bus", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b0, 16'h00FF, 1'b0));
      req_addr = 16'h0100; req = 1'b1;
      @(negedge CLOCK_50);
      check("abort_rd_lo", 32'({FL_OE_N, FL_ADDR}), bus_exp(1'b0, 16'h0100, 1'b0));
      first = 0;
      for (int k = 2; k <= 2*W + 4; k++) begin
         @(negedge CLOCK_50);
         if (insn_rdy) begin
            first = k;
            break;
         end
      end
      check("abort_lat", 32'(first), 32'(2*W + 1));
      check("abort_insn", 32'(insn), 32'(word(16'h0100)));
      req = 1'b0;
      @(negedge CLOCK_50);
      wait_idle();
      h_addr = 16'h0100; h_vld = 1'b1; p_addr = 16'h0101; p_vld = 1'b1;
      last_insn = word(16'h0100);
      run_req(16'h00FF, 12, 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
